// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one external combinational ALU between two requesters.
// Define ALU_ARB_PERF_EN to add the saturating per-requester grant counters.
module alu_arbiter #(
   parameter int WIDTH = 64
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [1:0]         req_valid,
   output logic [1:0]         req_ready,
   input  logic [2*WIDTH-1:0] req_a,
   input  logic [2*WIDTH-1:0] req_b,
   input  logic [5:0]         req_cntrl,
   output logic [1:0]         rsp_valid,
   input  logic [1:0]         rsp_ready,
   output logic [WIDTH-1:0]   rsp_result,
   output logic [3:0]         rsp_flags,
   output logic               rsp_err,
   output logic [WIDTH-1:0]   alu_a,
   output logic [WIDTH-1:0]   alu_b,
   output logic [2:0]         alu_cntrl,
   input  logic [WIDTH-1:0]   alu_result,
   input  logic [3:0]         alu_flags
`ifdef ALU_ARB_PERF_EN
   ,
   output logic [15:0]        perf_grants0,
   output logic [15:0]        perf_grants1
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic       owner;
   logic       last_grant;
   logic       op_err;
   logic       accept;
   logic       grant;
   logic [2:0] sel_cntrl;
   logic       sel_illegal;

   // Both valid: the requester that did not win last time goes next.
   always_comb begin
      state_nxt   = state;
      req_ready   = 2'b00;
      rsp_valid   = 2'b00;
      accept      = 1'b0;
      grant       = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid != 2'b00) begin
               accept    = 1'b1;
               grant     = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
               req_ready = grant ? 2'b10 : 2'b01;
               state_nxt = EXEC;
            end
         end
         EXEC: state_nxt = RESP;
         RESP: begin
            rsp_valid = owner ? 2'b10 : 2'b01;
            if (rsp_ready[owner]) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      sel_cntrl   = grant ? req_cntrl[5:3] : req_cntrl[2:0];
      sel_illegal = (sel_cntrl == 3'b001) || (sel_cntrl == 3'b111);
   end

   // The operand registers double as the ALU drive, so they hold outside EXEC.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_cntrl  <= 3'b000;
         op_err     <= 1'b0;
         rsp_result <= '0;
         rsp_flags  <= 4'b0000;
         rsp_err    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            owner      <= grant;
            last_grant <= grant;
            alu_a      <= grant ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
            alu_b      <= grant ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
            alu_cntrl  <= sel_illegal ? 3'b000 : sel_cntrl;
            op_err     <= sel_illegal;
         end
         if (state == EXEC) begin
            rsp_result <= op_err ? '0 : alu_result;
            rsp_flags  <= op_err ? 4'b0000 : alu_flags;
            rsp_err    <= op_err;
         end
      end
   end

`ifdef ALU_ARB_PERF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_grants0 <= 16'h0000;
         perf_grants1 <= 16'h0000;
      end else if (accept) begin
         if (!grant && perf_grants0 != 16'hFFFF) perf_grants0 <= perf_grants0 + 16'd1;
         if (grant && perf_grants1 != 16'hFFFF) perf_grants1 <= perf_grants1 + 16'd1;
      end
   end
`endif

endmodule
